// File: rtl/nb_position_broadcast_ctrl_if.sv
// Bus between the position broadcast sequencer and the position caches / preprocessor.
// slave = sequencer side, master = consumer/driver side.
interface nb_position_broadcast_ctrl_if #(
  parameter int NUM_NEIGHBOR_CELLS = 13,
  parameter int PARTICLE_ID_WIDTH  = 7
);
  logic                                                start;
  logic [(NUM_NEIGHBOR_CELLS+1)*PARTICLE_ID_WIDTH-1:0] cell_particle_count;
  logic [PARTICLE_ID_WIDTH-1:0]                        particle_id;
  logic                                                rd_en;
  logic [NUM_NEIGHBOR_CELLS:0]                         nb_valid;
  logic                                                phase;
  logic [NUM_NEIGHBOR_CELLS:0]                         broadcast_done;
  logic [PARTICLE_ID_WIDTH-1:0]                        ref_particle_number;
  logic [PARTICLE_ID_WIDTH-1:0]                        ref_index;
  logic                                                busy;
  logic                                                done;

  modport slave (
    input  start, cell_particle_count,
    output particle_id, rd_en, nb_valid, phase, broadcast_done,
           ref_particle_number, ref_index, busy, done
  );

  modport master (
    output start, cell_particle_count,
    input  particle_id, rd_en, nb_valid, phase, broadcast_done,
           ref_particle_number, ref_index, busy, done
  );
endinterface

// File: rtl/nb_position_broadcast_ctrl.sv
// Scans home + neighbour cell counts, then streams N0 sweeps of particle ids 1..L to the caches.
// Latency: first rd_en 15 cycles after start; no backpressure, start is ignored unless idle.
module nb_position_broadcast_ctrl #(
  parameter int NUM_NEIGHBOR_CELLS = 13,
  parameter int PARTICLE_ID_WIDTH  = 7
) (
  input logic                          clk,
  input logic                          rst,
  nb_position_broadcast_ctrl_if.slave  bus
);
  localparam int NC = NUM_NEIGHBOR_CELLS + 1;
  localparam int W  = PARTICLE_ID_WIDTH;
  localparam int SW = $clog2(NC);
  localparam logic [SW-1:0] SCAN_LAST = SW'(NC - 1);

  typedef enum logic [1:0] {IDLE, SCAN, STREAM, FINISH} state_t;

  state_t               state_q, state_d;
  logic [NC-1:0][W-1:0] cnt_q, cnt_d;
  logic [W-1:0]         len_q, len_d;
  logic [W-1:0]         n0_q, n0_d;
  logic [W-1:0]         pid_q, pid_d;
  logic [W-1:0]         ref_q, ref_d;
  logic [SW-1:0]        scan_q, scan_d;
  logic                 rd_en_q, rd_en_d;
  logic                 phase_q, phase_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [NC-1:0]        nbv_q, nbv_d;
  logic [NC-1:0]        bdone_q, bdone_d;
  logic [W-1:0]         len_max;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    n0_d    = n0_q;
    pid_d   = pid_q;
    ref_d   = ref_q;
    scan_d  = scan_q;
    rd_en_d = rd_en_q;
    phase_d = phase_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bdone_d = bdone_q;
    len_max = (cnt_q[scan_q] > len_q) ? cnt_q[scan_q] : len_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_d   = bus.cell_particle_count;
          n0_d    = bus.cell_particle_count[W-1:0];
          len_d   = '0;
          scan_d  = '0;
          busy_d  = 1'b1;
          bdone_d = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        len_d  = len_max;
        scan_d = scan_q + SW'(1);
        if (scan_q == SCAN_LAST) begin
          if (n0_q == '0 || len_max == '0) begin
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            bdone_d = '1;
          end else begin
            state_d = STREAM;
            pid_d   = W'(1);
            ref_d   = W'(1);
            phase_d = 1'b0;
            rd_en_d = 1'b1;
          end
        end
      end
      STREAM: begin
        // Each cell is done once the final sweep has issued its last particle.
        if (ref_q == n0_q) begin
          for (int c = 0; c < NC; c++) begin
            if (pid_q == cnt_q[c]) bdone_d[c] = 1'b1;
          end
        end
        if (pid_q == len_q) begin
          if (ref_q == n0_q) begin
            state_d = FINISH;
            pid_d   = '0;
            ref_d   = '0;
            rd_en_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            pid_d   = W'(1);
            ref_d   = ref_q + W'(1);
            phase_d = ~phase_q;
          end
        end else begin
          pid_d = pid_q + W'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Empty cells have nothing to send, so they complete as the final sweep begins.
    if (state_d == STREAM && ref_d == n0_q && pid_d == W'(1)) begin
      for (int c = 0; c < NC; c++) begin
        if (cnt_q[c] == '0) bdone_d[c] = 1'b1;
      end
    end

    for (int c = 0; c < NC; c++) begin
      nbv_d[c] = rd_en_d && (pid_d <= cnt_q[c]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      n0_q    <= '0;
      pid_q   <= '0;
      ref_q   <= '0;
      scan_q  <= '0;
      rd_en_q <= 1'b0;
      phase_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nbv_q   <= '0;
      bdone_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      n0_q    <= n0_d;
      pid_q   <= pid_d;
      ref_q   <= ref_d;
      scan_q  <= scan_d;
      rd_en_q <= rd_en_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      nbv_q   <= nbv_d;
      bdone_q <= bdone_d;
    end
  end

  assign bus.particle_id         = pid_q;
  assign bus.rd_en               = rd_en_q;
  assign bus.nb_valid            = nbv_q;
  assign bus.phase               = phase_q;
  assign bus.broadcast_done      = bdone_q;
  assign bus.ref_particle_number = n0_q;
  assign bus.ref_index           = ref_q;
  assign bus.busy                = busy_q;
  assign bus.done                = done_q;
endmodule
